vga_plot_arbiter: RTL and testbench
===================================

Name: vga_plot_arbiter

Overview:
- Shares the single VGA adapter pixel-write port (x, y, colour, plot) between several drawing datapaths: enemy datapath, player datapath and bullet/explosion datapath.
- Each requester presents one pixel per cycle with a request, and the block grants exactly one requester per cycle.
- Arbitration is round-robin with optional bounded burst locking, so a sprite is not interleaved with other sprites.
- Sits between the drawing datapaths and vga_adapter in the top level; it replaces the direct datapath-to-adapter connection.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MAX_BURST, 16, maximum consecutive grants to one locked owner before a forced hand-over (1..255).
- X_MAX, 159, largest legal x coordinate.
- Y_MAX, 119, largest legal y coordinate.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester pixel valid.
- lock  in  NUM_REQ  per-requester burst hold; only meaningful while that requester's req is high.
- x_in  in  NUM_REQ*8  packed x coordinates; requester i at bits [8i+7:8i].
- y_in  in  NUM_REQ*7  packed y coordinates; requester i at bits [7i+6:7i].
- colour_in  in  NUM_REQ*3  packed colours; requester i at bits [3i+2:3i].
- gnt  out  NUM_REQ  one-hot grant, combinational from req and registered state.
- x_out  out  8  registered x to vga_adapter.
- y_out  out  7  registered y to vga_adapter.
- colour_out  out  3  registered colour to vga_adapter.
- plot  out  1  registered write enable to vga_adapter.
- clip_cnt  out  16  saturating count of dropped out-of-range pixels.

Behaviour:
- Handshake:
  - A pixel from requester i is accepted in the cycle where req[i] and gnt[i] are both high.
  - A requester holds x/y/colour stable until accepted.
  - gnt is zero when req is zero.
  - gnt is never more than one-hot.
- Registered state:
  - owner: index, plus owner_valid.
  - last: index of the most recent grantee; the round-robin pointer.
  - burst_cnt: 8 bits.
- FSM has two states, IDLE and LOCKED.
- IDLE:
  - gnt goes to the first requester with req high, searching from last+1 modulo NUM_REQ.
  - On acceptance: last <= grantee.
  - If lock[grantee] is high on that cycle: go to LOCKED, owner <= grantee, burst_cnt <= 1.
- LOCKED:
  - If req[owner] and lock[owner] are high and burst_cnt < MAX_BURST: gnt = owner only; burst_cnt increments on acceptance.
  - If lock[owner] is low, or req[owner] is low: leave LOCKED this cycle. Arbitrate as IDLE in the same cycle, with the owner eligible and the search starting at owner+1. Next state is IDLE, or LOCKED with a new owner per the IDLE rules.
  - If burst_cnt == MAX_BURST: forced hand-over. Arbitrate as IDLE excluding the owner for this one cycle. If no other requester has req high, the owner may be regranted and burst_cnt restarts at 1.
- Output pipeline, latency 1 cycle from acceptance:
  - plot <= accepted and x <= X_MAX and y <= Y_MAX.
  - x_out, y_out and colour_out load the accepted pixel whenever a pixel is accepted, in range or not, and otherwise hold.
  - An out-of-range accepted pixel is consumed (granted) but not plotted; clip_cnt increments and saturates at 0xFFFF.
- Simultaneous events: several new requests in one cycle are resolved purely by round-robin order from last+1. A lock asserted by a non-owner has no effect until that requester is granted.
- Reset, including mid-burst:
  - Next edge forces IDLE, last = NUM_REQ-1 so requester 0 has first priority, burst_cnt = 0, plot = 0, x_out = 0, y_out = 0, colour_out = 0, clip_cnt = 0.
  - gnt is 0 during the reset cycle.
  - Pixels presented in the reset cycle are not accepted.
- Width rules: index fields are $clog2(NUM_REQ) bits. Round-robin wrap uses modulo NUM_REQ, not the power of two.

Decomposition:
- Shared package vga_pkg:
  - constants SCREEN_X_MAX=159, SCREEN_Y_MAX=119, X_W=8, Y_W=7, COLOUR_W=3.
  - typedef pixel_t {x, y, colour}.
- One natural sub-module: rr_pick. It is combinational, takes a request vector, start index and exclude mask, and returns one-hot plus index. Both the IDLE and forced hand-over paths use it.

Test Plan:
- Reset, then req=3'b111, lock=0, held 6 cycles -> gnt sequence 001,010,100,001,010,100. plot high from cycle 2; x_out follows each grantee's x one cycle later.
- Requester 1 sets lock=1 and holds req for 20 cycles while 0 and 2 request; MAX_BURST=16 -> 16 consecutive gnt=010, then gnt=100, then 001, then 010 again.
- Requester 0 presents x=160, y=10, then x=5, y=120, then x=159, y=119 -> all three granted. plot stays 0 for the first two and is 1 for the third. clip_cnt=2.
- Owner 2 locked, drops lock mid-burst at burst_cnt=5 while req=3'b011 -> the next grant goes to 0, then 1 (search from 3 mod 3 = 0). State returns to IDLE.
- Reset asserted in the middle of a locked burst by requester 1 -> next cycle gnt=0 and plot=0. After release with req=3'b110, the first grant is 010.
- A single requester with lock and MAX_BURST=4 held 10 cycles, others idle -> continuous gnt=001 with no bubble. burst_cnt wraps 1..4 and restarts at 1.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Screen geometry and pixel record shared by the VGA drawing blocks.
// Revision : 1.0
// ============================================================================
package vga_pkg;

    localparam int SCREEN_X_MAX = 159;
    localparam int SCREEN_Y_MAX = 119;
    localparam int X_W          = 8;
    localparam int Y_W          = 7;
    localparam int COLOUR_W     = 3;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

endpackage
`default_nettype wire

// File: rtl/vga_plot_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first eligible request at or
//            after i_start (modulo NUM_REQ), masked by i_exclude.
// Revision : 1.0
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_start,
    input  logic [NUM_REQ-1:0] i_exclude,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    logic [NUM_REQ-1:0] w_elig;
    logic [IDX_W:0]     w_cand;

    // Scan from the farthest offset down so the nearest eligible one wins.
    always_comb begin
        w_elig   = i_req & ~i_exclude;
        w_cand   = '0;
        o_onehot = '0;
        o_idx    = '0;
        o_found  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, i_start} + (IDX_W + 1)'(k);
            if (w_cand >= (IDX_W + 1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (w_elig[w_cand[IDX_W-1:0]]) begin
                o_found  = 1'b1;
                o_idx    = w_cand[IDX_W-1:0];
                o_onehot = '0;
                o_onehot[w_cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_plot_arbiter
// Brief    : Round-robin arbiter with bounded burst locking that shares the
//            vga_adapter pixel-write port between the drawing datapaths.
// Revision : 1.0
// ============================================================================
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 16,
    parameter int X_MAX     = SCREEN_X_MAX,
    parameter int Y_MAX     = SCREEN_Y_MAX
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*X_W-1:0]        x_in,
    input  logic [NUM_REQ*Y_W-1:0]        y_in,
    input  logic [NUM_REQ*COLOUR_W-1:0]   colour_in,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [X_W-1:0]                x_out,
    output logic [Y_W-1:0]                y_out,
    output logic [COLOUR_W-1:0]           colour_out,
    output logic                          plot,
    output logic [15:0]                   clip_cnt
);

    localparam int         IDX_W    = $clog2(NUM_REQ);
    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;

    logic [0:0]         r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last;
    logic [7:0]         r_burst_cnt;
    pixel_t             r_pix;
    logic               r_plot;
    logic [15:0]        r_clip_cnt;

    logic [IDX_W-1:0]   w_owner_next;
    logic [IDX_W-1:0]   w_last_next;
    logic               w_owner_live;
    logic               w_hold;
    logic               w_forced;
    logic [IDX_W-1:0]   w_start;
    logic [NUM_REQ-1:0] w_excl;
    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_found;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_idx;
    logic               w_accept;
    pixel_t             w_pix;
    logic               w_in_range;

    assign w_owner_next = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_last_next  = (r_last  == IDX_W'(NUM_REQ - 1)) ? '0 : r_last  + 1'b1;
    assign w_owner_live = (r_state == c_LOCKED) && req[r_owner] && lock[r_owner];
    assign w_hold       = w_owner_live && (r_burst_cnt < 8'(MAX_BURST));
    assign w_forced     = w_owner_live && !w_hold;
    assign w_start      = (r_state == c_LOCKED) ? w_owner_next : w_last_next;

    always_comb begin
        w_excl          = '0;
        w_excl[r_owner] = w_forced;
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req     (req),
        .i_start   (w_start),
        .i_exclude (w_excl),
        .o_onehot  (w_pick_gnt),
        .o_idx     (w_pick_idx),
        .o_found   (w_pick_found)
    );

    // A forced hand-over with no competitor falls back to the owner.
    always_comb begin
        w_gnt = '0;
        w_idx = '0;
        if (reset) begin
            w_gnt = '0;
        end else if (w_hold) begin
            w_gnt[r_owner] = 1'b1;
            w_idx          = r_owner;
        end else if (w_pick_found) begin
            w_gnt = w_pick_gnt;
            w_idx = w_pick_idx;
        end else if (w_forced) begin
            w_gnt[r_owner] = 1'b1;
            w_idx          = r_owner;
        end
    end

    assign w_accept     = |w_gnt;
    assign w_pix.x      = x_in[int'(w_idx)*X_W +: X_W];
    assign w_pix.y      = y_in[int'(w_idx)*Y_W +: Y_W];
    assign w_pix.colour = colour_in[int'(w_idx)*COLOUR_W +: COLOUR_W];
    assign w_in_range   = (w_pix.x <= X_W'(X_MAX)) && (w_pix.y <= Y_W'(Y_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_owner     <= '0;
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_burst_cnt <= '0;
            r_pix       <= '0;
            r_plot      <= 1'b0;
            r_clip_cnt  <= '0;
        end else begin
            r_plot <= w_accept && w_in_range;
            if (w_accept) begin
                r_pix  <= w_pix;
                r_last <= w_idx;
                if (!w_in_range && (r_clip_cnt != 16'hFFFF)) begin
                    r_clip_cnt <= r_clip_cnt + 16'd1;
                end
            end
            if (w_hold) begin
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end else if (w_accept && lock[w_idx]) begin
                r_state     <= c_LOCKED;
                r_owner     <= w_idx;
                r_burst_cnt <= 8'd1;
            end else begin
                r_state     <= c_IDLE;
                r_burst_cnt <= '0;
            end
        end
    end

    assign gnt        = w_gnt;
    assign x_out      = r_pix.x;
    assign y_out      = r_pix.y;
    assign colour_out = r_pix.colour;
    assign plot       = r_plot;
    assign clip_cnt   = r_clip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_plot_arbiter
// Brief    : Directed self-checking bench for vga_plot_arbiter.
// Revision : 1.0
// ============================================================================
module tb_vga_plot_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req,  lock,  gnt;
    logic [23:0] x_in;
    logic [20:0] y_in;
    logic [8:0]  c_in;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  c_out;
    logic        plot;
    logic [15:0] clip_cnt;

    logic [2:0]  req4, lock4, gnt4;
    logic [23:0] x4_in;
    logic [20:0] y4_in;
    logic [8:0]  c4_in;
    logic [7:0]  x4_out;
    logic [6:0]  y4_out;
    logic [2:0]  c4_out;
    logic        plot4;
    logic [15:0] clip4_cnt;

    int n_cmp = 0;
    int n_err = 0;

    vga_plot_arbiter #(.NUM_REQ(3), .MAX_BURST(16)) dut (
        .clk(clk), .reset(rst), .req(req), .lock(lock),
        .x_in(x_in), .y_in(y_in), .colour_in(c_in), .gnt(gnt),
        .x_out(x_out), .y_out(y_out), .colour_out(c_out),
        .plot(plot), .clip_cnt(clip_cnt)
    );

    vga_plot_arbiter #(.NUM_REQ(3), .MAX_BURST(4)) dut4 (
        .clk(clk), .reset(rst), .req(req4), .lock(lock4),
        .x_in(x4_in), .y_in(y4_in), .colour_in(c4_in), .gnt(gnt4),
        .x_out(x4_out), .y_out(y4_out), .colour_out(c4_out),
        .plot(plot4), .clip_cnt(clip4_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        x_in[i*8 +: 8] = x;
        y_in[i*7 +: 7] = y;
        c_in[i*3 +: 3] = c;
    endtask

    logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [7:0] exp_x [6] = '{8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30};

    initial begin
        rst = 1'b1;
        req = 3'b111; lock = '0; x_in = '0; y_in = '0; c_in = '0;
        req4 = '0; lock4 = '0; x4_in = '0; y4_in = '0; c4_in = '0;
        set_px(0, 8'd10, 7'd1, 3'd1);
        set_px(1, 8'd20, 7'd2, 3'd2);
        set_px(2, 8'd30, 7'd3, 3'd3);
        repeat (3) tick;
        #1;
        check_eq("rst_gnt", gnt, 3'b000);
        check_eq("rst_plot", plot, 1'b0);
        check_eq("rst_x", x_out, 8'd0);
        check_eq("rst_y", y_out, 7'd0);
        check_eq("rst_col", c_out, 3'd0);
        check_eq("rst_clip", clip_cnt, 16'd0);

        // plain round robin, no lock
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_eq($sformatf("rr_gnt%0d", k), gnt, exp_g[k]);
            tick;
            check_eq($sformatf("rr_plot%0d", k), plot, 1'b1);
            check_eq($sformatf("rr_x%0d", k), x_out, exp_x[k]);
        end

        // locked burst on requester 1, forced hand-over at 16
        req = 3'b010; lock = 3'b010;
        #1; check_eq("burst_first", gnt, 3'b010);
        tick;
        req = 3'b111;
        for (int k = 0; k < 15; k++) begin
            #1; check_eq($sformatf("burst_hold%0d", k), gnt, 3'b010);
            tick;
        end
        #1; check_eq("burst_handover", gnt, 3'b100); tick;
        #1; check_eq("burst_next0", gnt, 3'b001); tick;
        #1; check_eq("burst_back1", gnt, 3'b010); tick;
        req = '0; lock = '0;
        #1; check_eq("idle_gnt", gnt, 3'b000); tick;

        // clipping
        req = 3'b001;
        set_px(0, 8'd160, 7'd10, 3'd5);
        #1; check_eq("clip_gnt", gnt, 3'b001); tick;
        check_eq("clip1_plot", plot, 1'b0);
        check_eq("clip1_x", x_out, 8'd160);
        check_eq("clip1_cnt", clip_cnt, 16'd1);
        set_px(0, 8'd5, 7'd120, 3'd6); tick;
        check_eq("clip2_plot", plot, 1'b0);
        check_eq("clip2_y", y_out, 7'd120);
        check_eq("clip2_cnt", clip_cnt, 16'd2);
        set_px(0, 8'd159, 7'd119, 3'd7); tick;
        check_eq("edge_plot", plot, 1'b1);
        check_eq("edge_x", x_out, 8'd159);
        check_eq("edge_y", y_out, 7'd119);
        check_eq("edge_col", c_out, 3'd7);
        check_eq("edge_cnt", clip_cnt, 16'd2);
        req = '0; tick;
        check_eq("noacc_plot", plot, 1'b0);
        check_eq("noacc_hold_x", x_out, 8'd159);

        // owner 2 drops lock after 5 grants
        set_px(0, 8'd10, 7'd1, 3'd1);
        req = 3'b100; lock = 3'b100;
        for (int k = 0; k < 5; k++) begin
            #1; check_eq($sformatf("own2_%0d", k), gnt, 3'b100);
            tick;
        end
        req = 3'b011; lock = '0;
        #1; check_eq("drop_gnt0", gnt, 3'b001); tick;
        check_eq("drop_x0", x_out, 8'd10);
        #1; check_eq("drop_gnt1", gnt, 3'b010); tick;
        check_eq("drop_x1", x_out, 8'd20);
        #1; check_eq("drop_idle", gnt, 3'b001); tick;

        // reset in the middle of a burst
        req = 3'b010; lock = 3'b010;
        #1; check_eq("rb_gnt0", gnt, 3'b010); tick;
        #1; check_eq("rb_gnt1", gnt, 3'b010);
        rst = 1'b1;
        #1; check_eq("rb_rst_gnt", gnt, 3'b000);
        tick;
        check_eq("rb_plot", plot, 1'b0);
        check_eq("rb_x", x_out, 8'd0);
        check_eq("rb_clip", clip_cnt, 16'd0);
        rst = 1'b0; req = 3'b110; lock = '0;
        #1; check_eq("rb_first", gnt, 3'b010); tick;
        check_eq("rb_first_x", x_out, 8'd20);
        req = '0;

        // single locked requester with MAX_BURST=4: no bubbles
        x4_in[7:0] = 8'd50; y4_in[6:0] = 7'd50; c4_in[2:0] = 3'd2;
        x4_in[15:8] = 8'd60; y4_in[13:7] = 7'd60; c4_in[5:3] = 3'd3;
        req4 = 3'b001; lock4 = 3'b001;
        for (int k = 0; k < 10; k++) begin
            #1; check_eq($sformatf("solo_gnt%0d", k), gnt4, 3'b001);
            tick;
            check_eq($sformatf("solo_plot%0d", k), plot4, 1'b1);
        end
        req4 = 3'b011;
        #1; check_eq("b4_hold3", gnt4, 3'b001); tick;
        #1; check_eq("b4_hold4", gnt4, 3'b001); tick;
        #1; check_eq("b4_handover", gnt4, 3'b010); tick;
        check_eq("b4_x", x4_out, 8'd60);
        #1; check_eq("b4_back0", gnt4, 3'b001); tick;
        check_eq("b4_x0", x4_out, 8'd50);
        req4 = '0; lock4 = '0;
        #1; check_eq("b4_idle", gnt4, 3'b000);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
